// File: rtl/noc_in_fifo_port_if.sv
// Avalon-MM slave plus NoC valid-qualified input bundle for noc_in_fifo_port.
interface noc_in_fifo_port_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              irq;

  modport master (
    output address, read, write, writedata, in_data, in_valid,
    input  readdata, irq
  );

  modport slave (
    input  address, read, write, writedata, in_data, in_valid,
    output readdata, irq
  );
endinterface

// File: rtl/noc_in_fifo_port.sv
// Buffered NoC input port: FIFO behind DATA/STATUS/CONTROL Avalon registers.
// Optional interrupt logic is built only when NOC_IN_IRQ_EN is defined.
module noc_in_fifo_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  noc_in_fifo_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic empty, full, data_rd, pop, push, flush, sts_wr;
  logic irq_en_rd;
  logic [DATA_W-1:0] status;
  logic unused_wdata;

  assign unused_wdata = ^bus.writedata;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    data_rd = bus.read && (bus.address == 2'd0);
    pop     = data_rd && !empty;
    flush   = bus.write && (bus.address == 2'd2) && bus.writedata[1];
    sts_wr  = bus.write && (bus.address == 2'd1);
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    push    = bus.in_valid && (!full || pop) && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Set beats clear when both land on the same edge.
    ovf_d = (ovf_q & ~(sts_wr & bus.writedata[2]))
          | (bus.in_valid && full && !pop && !flush);
    unf_d = (unf_q & ~(sts_wr & bus.writedata[3])) | (data_rd && empty);

    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = ovf_q;
    status[3]      = unf_q;
    status[8 +: CW] = count_q;

    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = empty ? '0 : mem_q[rd_ptr_q];
      2'd1:    readdata_d = status;
      2'd2:    readdata_d[0] = irq_en_rd;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.readdata = readdata_q;

`ifdef NOC_IN_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (bus.write && (bus.address == 2'd2)) irq_en_q <= bus.writedata[0];
      irq_q <= irq_en_q & (!empty | ovf_q);
    end
  end

  assign irq_en_rd = irq_en_q;
  assign bus.irq   = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign bus.irq   = 1'b0;
`endif
endmodule

// File: tb/tb_noc_in_fifo_port.sv
// Scoreboard bench for noc_in_fifo_port: a queue model predicts readdata, status and irq.
module tb_noc_in_fifo_port;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  noc_in_fifo_port_if #(.DATA_W(DW)) bus ();

  noc_in_fifo_port #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sb[$];
  logic ovf_m, unf_m, irq_en_m;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] status_m();
    logic [DW-1:0] s;
    s       = '0;
    s[0]    = (sb.size() == 0);
    s[1]    = (sb.size() == DEPTH);
    s[2]    = ovf_m;
    s[3]    = unf_m;
    s[15:8] = 8'(sb.size());
    return s;
  endfunction

  // One clock: drive inputs, predict, advance the model, then check after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [DW-1:0] wd, input string tag);
    logic [DW-1:0] exp_rd;
    logic exp_irq;
    bit empty, full, pop, flush;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
    empty = (sb.size() == 0);
    full  = (sb.size() == DEPTH);
    case (a)
      2'd0:    exp_rd = empty ? '0 : sb[0];
      2'd1:    exp_rd = status_m();
      2'd2:    exp_rd = DW'(irq_en_m);
      default: exp_rd = '0;
    endcase
    exp_irq = irq_en_m & (!empty | ovf_m);
    pop   = rd && (a == 2'd0) && !empty;
    flush = wr && (a == 2'd2) && wd[1];
    if (wr && (a == 2'd1)) begin
      if (wd[2]) ovf_m = 1'b0;
      if (wd[3]) unf_m = 1'b0;
    end
    if (v && full && !pop && !flush) ovf_m = 1'b1;
    if (rd && (a == 2'd0) && empty) unf_m = 1'b1;
`ifdef NOC_IN_IRQ_EN
    if (wr && (a == 2'd2)) irq_en_m = wd[0];
`endif
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (v && (!full || pop)) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    if (rd) check(tag, bus.readdata, exp_rd);
    check({tag, "_irq"}, DW'(bus.irq), DW'(exp_irq));
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 2'd0, '0, "push");
  endtask

  task automatic rd(input logic [1:0] a, input string tag);
    cycle(1'b0, '0, 1'b1, 1'b0, a, '0, tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] wd);
    cycle(1'b0, '0, 1'b0, 1'b1, a, wd, "wr");
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
    irq_en_m = 1'b0;
    check("rst_rdata", bus.readdata, '0);
    check("rst_irq", DW'(bus.irq), '0);
  endtask

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.in_data = '0; bus.in_valid = 1'b0;
    ovf_m = 1'b0; unf_m = 1'b0; irq_en_m = 1'b0;
    do_reset();

    // Register map after reset
    rd(2'd1, "rst_status");
    check("rst_status_lit", bus.readdata, 32'h1);
    rd(2'd2, "rst_ctrl");
    rd(2'd3, "rst_a3");
    rd(2'd0, "rst_data");
    wr(2'd1, 32'h8);

    // Basic ordering
    push(32'hA1); push(32'hB2); push(32'hC3);
    rd(2'd0, "abc0"); rd(2'd0, "abc1"); rd(2'd0, "abc2");
    rd(2'd1, "abc_status");
    check("abc_status_lit", bus.readdata, 32'h1);

    // Overflow on the 17th word, W1C, drain
    for (int i = 0; i <= 16; i++) push(DW'(i));
    rd(2'd1, "ovf_status");
    check("ovf_status_lit", bus.readdata, 32'h1006);
    wr(2'd1, 32'h4);
    rd(2'd1, "ovf_clr_status");
    check("ovf_clr_lit", bus.readdata, 32'h1002);
    for (int i = 0; i < DEPTH; i++) rd(2'd0, "drain_ovf");
    rd(2'd1, "drained_status");

    // Push into a full FIFO alongside a pop
    for (int i = 0; i < DEPTH; i++) push(DW'(32'h100 + i));
    cycle(1'b1, 32'h55, 1'b1, 1'b0, 2'd0, '0, "full_pushpop");
    rd(2'd1, "full_pushpop_status");
    check("full_pushpop_lit", bus.readdata, 32'h1002);
    for (int i = 0; i < DEPTH; i++) rd(2'd0, "drain_pp");
    check("last_is_55", bus.readdata, 32'h55);

    // Underflow, pointers untouched
    rd(2'd0, "unf_data");
    check("unf_data_lit", bus.readdata, 32'h0);
    rd(2'd1, "unf_status");
    check("unf_status_lit", bus.readdata, 32'h9);
    push(32'h77);
    rd(2'd0, "after_unf");
    check("after_unf_lit", bus.readdata, 32'h77);
    wr(2'd1, 32'h8);

    // Overflow set and clear on the same edge: set wins
    for (int i = 0; i < DEPTH; i++) push(DW'(32'h200 + i));
    cycle(1'b1, 32'h99, 1'b0, 1'b1, 2'd1, 32'h4, "set_vs_clr");
    rd(2'd1, "set_vs_clr_status");
    check("set_vs_clr_lit", bus.readdata, 32'h1006);
    wr(2'd1, 32'h4);
    for (int i = 0; i < DEPTH; i++) rd(2'd0, "drain_svc");

    // Interrupt enable and flush
    wr(2'd2, 32'h1);
    rd(2'd2, "ctrl_rb");
    push(32'h10);
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, "irq_pending");
    rd(2'd0, "irq_pop");
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, "irq_cleared");
    push(32'h1); push(32'h2); push(32'h3);
    cycle(1'b1, 32'hEE, 1'b0, 1'b1, 2'd2, 32'h3, "flush_push");
    rd(2'd1, "flush_status");
    check("flush_status_lit", bus.readdata, 32'h1);
    rd(2'd2, "ctrl_after_flush");
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, "flush_idle");

    // Writes to DATA ignored; reset discards queued words
    wr(2'd0, 32'hDEAD);
    wr(2'd3, 32'hFFFF);
    rd(2'd3, "a3_after_wr");
    for (int i = 0; i < 5; i++) push(DW'(32'h300 + i));
    do_reset();
    rd(2'd1, "mid_reset_status");
    check("mid_reset_lit", bus.readdata, 32'h1);

    // Random mix of pushes, pops, status reads and sticky clears
    wr(2'd2, 32'h1);
    for (int i = 0; i < 400; i++) begin
      logic v, r, w;
      logic [1:0] a;
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
      w = ($urandom_range(0, 15) == 0);
      if (w) cycle(v, DW'($urandom), 1'b0, 1'b1, 2'd1, 32'hC, "rand_clr");
      else   cycle(v, DW'($urandom), r, 1'b0, a, '0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/noc_in_fifo_port.md
# noc_in_fifo_port

Buffered, parametrised NoC input port for the Nios system. Receives words from the NoC on a valid-qualified input bus, queues them in a FIFO, and presents them to the processor as an Avalon-MM slave with data, status and control registers. An optional interrupt signals pending data or overflow.

## Interface
Parameters:
- DATA_W, 32: NoC word and readdata width; range 16..32.
- DEPTH, 16: FIFO depth in words; power of two, 2..128.

Ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  registered read data.
- in_data  in  DATA_W  NoC word.
- in_valid  in  1  in_data is valid this cycle; no backpressure.
- irq  out  1  level interrupt.

## Operation
- FIFO: circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits that wrap modulo DEPTH, plus count of clog2(DEPTH)+1 bits. empty = (count==0). full = (count==DEPTH).
- Push: in_valid=1 and not full → write at wr_ptr, increment wr_ptr.
- Push while full with no pop in the same cycle → word dropped and overflow sticky set.
- Push while full with a pop in the same cycle → word accepted; count stays DEPTH.
- Pop: read=1, address=0, not empty → increment rd_ptr.
- Pop while empty → no pointer change; underflow sticky set.
- Simultaneous push and pop (not empty) → count unchanged.
- DATA register (address 0, read-only) returns the head word at rd_ptr. When empty it returns 0.
- STATUS register (address 1):
  - bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bits[15:8] count, zero-extended; other bits 0.
  - Write: writing 1 to bit2 or bit3 clears that sticky bit (write-1-to-clear).
  - Setting a sticky bit in the same cycle as its clear → bit stays set.
- CONTROL register (address 2):
  - bit0 irq_en, read/write.
  - bit1 flush: write 1 zeroes both pointers and count. Not stored; the bit reads 0.
  - Flush in the same cycle as a push → flush wins, word discarded, overflow not set.
- Address 3 reads 0; writes to it are ignored. Writes to DATA are ignored.
- irq = irq_en & (!empty | overflow).

## Timing
- Reset (synchronous, at the edge with reset=1): pointers, count, sticky bits, irq_en and readdata are all 0; irq=0.
- readdata is registered on every edge from the address mux, whether or not read is asserted. Read latency is 1 cycle.
- A pop performed at edge N returns, in readdata after edge N, the head value from before the pop.
- A word pushed at edge N is reflected in count/empty from edge N onward: STATUS sampled at cycle N+1 shows it in readdata after edge N+1.
- irq is registered: it reflects state one cycle after the causing edge.
- Reset asserted mid-stream discards all queued words; in_valid during reset is ignored.
- Throughput: one push and one pop per cycle.

## Configuration
- NOC_IN_IRQ_EN defined: the irq logic and CONTROL.irq_en are implemented as described above.
- NOC_IN_IRQ_EN undefined: irq is tied to 0, CONTROL bit0 reads 0 and ignores writes, and there is no interrupt register logic. FIFO behaviour is unchanged.

## Test plan
- Reset, then read all addresses → readdata=0 for each; STATUS=0x1 (empty); irq=0.
- Push 0xA1, 0xB2, 0xC3 over consecutive cycles, then read DATA three times → readdata 0xA1, 0xB2, 0xC3; STATUS afterwards = 0x1.
- DEPTH=16: push 17 words 0..16 → STATUS = 0x1006 (count 16, full, overflow); drain returns 0..15. Write STATUS with 0x4 → overflow cleared.
- Fill to full, then push 0x55 in the same cycle as a DATA pop → 0x55 accepted, count stays 16, overflow stays 0; 0x55 is the last word drained.
- Read DATA while empty → readdata=0 and underflow set (STATUS=0x9). Pointers unchanged: a subsequent push of 0x77 reads back 0x77.
- With NOC_IN_IRQ_EN: write CONTROL=0x1, push 0x10 → irq=1 one cycle later; pop → irq=0. Write CONTROL=0x2 with 3 words queued → count 0, irq=0. Assert reset with 5 words queued → STATUS=0x1.
